// File: rtl/if_fetch.sv
// Instruction fetch: single-outstanding memory request, 2-entry {addr, ins} queue to IFID.
// Optional macro FETCH_PERF_CNT_EN builds the delivered-instruction counter.
module if_fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clkIn,
    input  logic        resetIn,
    input  logic        stallIn,
    input  logic        redirectIn,
    input  logic [31:0] redirectAddrIn,
    output logic        memReqOut,
    output logic [31:0] memAddrOut,
    input  logic        memReadyIn,
    input  logic [31:0] memDataIn,
    output logic [31:0] InsOut,
    output logic [31:0] AddrOut,
    output logic        validOut,
    output logic [31:0] fetchCountOut
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DROP
    } state_t;

    state_t      r_state;
    state_t      w_stateNxt;
    logic [31:0] r_pc;
    logic [31:0] r_reqAddr;
    logic [31:0] r_addr0;
    logic [31:0] r_addr1;
    logic [31:0] r_ins0;
    logic [31:0] r_ins1;
    logic [1:0]  r_count;

    logic        w_pop;
    logic        w_push;
    logic        w_issue;
    logic [1:0]  w_level;
    logic        w_wrIdx;
    logic [31:0] w_target;

    assign w_pop    = (r_count != 2'd0) && !stallIn && !redirectIn;
    assign w_push   = (r_state == ST_WAIT) && memReadyIn && !redirectIn;
    assign w_level  = r_count - {1'b0, w_pop};
    assign w_wrIdx  = w_level[0];
    assign w_issue  = (r_state == ST_IDLE) && !redirectIn && !resetIn
                      && (w_level < 2'd2);
    assign w_target = redirectAddrIn & 32'hFFFF_FFFC;

    assign memReqOut  = w_issue;
    assign memAddrOut = r_pc;
    assign validOut   = (r_count != 2'd0);
    assign InsOut     = validOut ? r_ins0 : 32'h0;
    assign AddrOut    = validOut ? r_addr0 : 32'h0;

    always_comb begin
        w_stateNxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_issue)
                    w_stateNxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (memReadyIn)
                    w_stateNxt = ST_IDLE;
                else if (redirectIn)
                    w_stateNxt = ST_DROP;
            end
            ST_DROP: begin
                if (memReadyIn)
                    w_stateNxt = ST_IDLE;
            end
            default: w_stateNxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clkIn or posedge resetIn) begin
        if (resetIn)
            r_state <= ST_IDLE;
        else
            r_state <= w_stateNxt;
    end

    always_ff @(posedge clkIn or posedge resetIn) begin
        if (resetIn) begin
            r_pc      <= RESET_VECTOR;
            r_reqAddr <= 32'h0;
        end else if (redirectIn) begin
            r_pc <= w_target;
        end else if (w_issue) begin
            r_reqAddr <= r_pc;
            r_pc      <= r_pc + 32'd4;
        end
    end

    // Pop shifts first; a push into slot 0 then overrides the shift.
    always_ff @(posedge clkIn or posedge resetIn) begin
        if (resetIn) begin
            r_count <= 2'd0;
            r_addr0 <= 32'h0;
            r_addr1 <= 32'h0;
            r_ins0  <= 32'h0;
            r_ins1  <= 32'h0;
        end else if (redirectIn) begin
            r_count <= 2'd0;
        end else begin
            if (w_pop) begin
                r_addr0 <= r_addr1;
                r_ins0  <= r_ins1;
            end
            if (w_push) begin
                if (w_wrIdx) begin
                    r_addr1 <= r_reqAddr;
                    r_ins1  <= memDataIn;
                end else begin
                    r_addr0 <= r_reqAddr;
                    r_ins0  <= memDataIn;
                end
            end
            r_count <= w_level + {1'b0, w_push};
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_fetchCnt;

    always_ff @(posedge clkIn or posedge resetIn) begin
        if (resetIn)
            r_fetchCnt <= 32'h0;
        else if (w_pop)
            r_fetchCnt <= r_fetchCnt + 32'd1;
    end

    assign fetchCountOut = r_fetchCnt;
`else
    assign fetchCountOut = 32'h0;
`endif

endmodule
